// File: rtl/vga_timing_gen.sv
// Programmable raster timing generator (default 640x480@60) with a pixel clock enable.
// Outputs are registered from the pre-increment counters, so they lag the counters by one ce-cycle.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0,
    parameter int FRAME_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ce,
    output logic               hsync,
    output logic               vsync,
    output logic               blank,
    output logic [10:0]        x,
    output logic [9:0]         y,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_VIS        = 11'(H_VISIBLE);
    localparam logic [10:0] H_SYNC_START = 11'(H_VISIBLE + H_FP);
    localparam logic [10:0] H_SYNC_END   = 11'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0]  V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_VIS        = 10'(V_VISIBLE);
    localparam logic [9:0]  V_SYNC_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0]  V_SYNC_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

    localparam logic HS_ON  = (HSYNC_POL != 0);
    localparam logic HS_OFF = (HSYNC_POL == 0);
    localparam logic VS_ON  = (VSYNC_POL != 0);
    localparam logic VS_OFF = (VSYNC_POL == 0);

    logic [10:0] h_cnt;
    logic [9:0]  v_cnt;
    logic        frame_wrap;

    logic h_last;
    logic v_last;
    logic in_hsync;
    logic in_vsync;
    logic visible;

    assign h_last   = (h_cnt == H_LAST);
    assign v_last   = (v_cnt == V_LAST);
    assign in_hsync = (h_cnt >= H_SYNC_START) && (h_cnt < H_SYNC_END);
    assign in_vsync = (v_cnt >= V_SYNC_START) && (v_cnt < V_SYNC_END);
    assign visible  = (h_cnt < H_VIS) && (v_cnt < V_VIS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (ce) begin
            h_cnt <= h_last ? '0 : h_cnt + 11'd1;
            if (h_last) begin
                v_cnt <= v_last ? '0 : v_cnt + 10'd1;
            end
        end
    end

    // frame_wrap delays the counter wrap by one ce-cycle so frame_cnt steps
    // together with the output that shows (0,0) of the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_wrap <= 1'b0;
            frame_cnt  <= '0;
        end else if (ce) begin
            frame_wrap <= h_last && v_last;
            if (frame_wrap) begin
                frame_cnt <= frame_cnt + FRAME_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync       <= HS_OFF;
            vsync       <= VS_OFF;
            blank       <= 1'b1;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (ce) begin
                hsync       <= in_hsync ? HS_ON : HS_OFF;
                vsync       <= in_vsync ? VS_ON : VS_OFF;
                blank       <= !visible;
                x           <= h_cnt;
                y           <= v_cnt;
                line_start  <= (h_cnt == '0);
                frame_start <= (h_cnt == '0) && (v_cnt == '0);
            end
        end
    end

endmodule
